// File: rtl/csel_sub_pkg.sv
// ---------------------------------------------------------------------------
// csel_sub_pkg
//
// Shared definitions for the iterative carry-select subtractor:
//   - csel_sub_state_e : FSM state type (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH / DEFAULT_SLICE : default operand width and slice width
//   - calc_num_slices() : number of SLICE-wide chunks in a WIDTH-bit operand
//   - calc_idx_w()      : width of the slice index, $clog2(num_slices), min 1
// ---------------------------------------------------------------------------
package csel_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } csel_sub_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  function automatic int calc_num_slices(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice configuration still needs a 1-bit index register so the
  // index compare logic stays uniform.
  function automatic int calc_idx_w(input int num_slices);
    int w;
    w = $clog2(num_slices);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/csel_sub_slice.sv
// ---------------------------------------------------------------------------
// csel_sub_slice
//
// Combinational SLICE-bit subtract unit. Produces both candidate results of
// a_s - b_s - bi in parallel, one for bi = 0 and one for bi = 1; the caller
// picks one with its registered running borrow.
//
// Ports:
//   a_s  in  SLICE  minuend slice
//   b_s  in  SLICE  subtrahend slice
//   d0   out SLICE  difference assuming borrow-in 0
//   bo0  out 1      borrow-out assuming borrow-in 0
//   d1   out SLICE  difference assuming borrow-in 1
//   bo1  out 1      borrow-out assuming borrow-in 1
// ---------------------------------------------------------------------------
module csel_sub_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic [SLICE-1:0] d0,
  output logic             bo0,
  output logic [SLICE-1:0] d1,
  output logic             bo1
);

  // Both results are evaluated one bit wider than the slice: the extra MSB of
  // the zero-extended subtraction is exactly the borrow-out.
  logic [SLICE:0] r0;
  logic [SLICE:0] r1;

  always_comb begin
    r0 = {1'b0, a_s} - {1'b0, b_s};
    r1 = {1'b0, a_s} - {1'b0, b_s} - {{SLICE{1'b0}}, 1'b1};
  end

  assign d0  = r0[SLICE-1:0];
  assign bo0 = r0[SLICE];
  assign d1  = r1[SLICE-1:0];
  assign bo1 = r1[SLICE];

endmodule

// File: rtl/csel_iter_subtractor.sv
// ---------------------------------------------------------------------------
// csel_iter_subtractor
//
// Iterative multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH),
// processed SLICE bits per clock. Each slice is evaluated carry-select style
// by csel_sub_slice (both borrow-in candidates), and the registered running
// borrow selects the one that applies.
//
// Optional feature: define CSEL_SUB_SIGNED_OVF_EN to add the 'ovf' output
// (two's-complement overflow of the subtraction).
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, bin valid
//   in_ready   out  1      block can accept a new operation (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - bin mod 2^WIDTH
//   bout       out  1      borrow-out: 1 iff a < b + bin (unsigned)
//   ovf        out  1      signed overflow (only with CSEL_SUB_SIGNED_OVF_EN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The operand side transfers only in IDLE (in_ready = 1); the bus
// is sampled on that edge only. The result side transfers only in DONE
// (out_valid = 1); diff/bout stay stable until that edge. valid is never
// withdrawn by this block before the transfer, and ready/valid outside
// their states are ignored.
// ---------------------------------------------------------------------------
module csel_iter_subtractor
  import csel_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSEL_SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_SLICES = calc_num_slices(WIDTH, SLICE);
  localparam int IDX_W      = calc_idx_w(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  csel_sub_state_e   state_q,  state_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  a_q,      a_d;
  logic [WIDTH-1:0]  b_q,      b_d;
  logic [WIDTH-1:0]  diff_q,   diff_d;
  logic              bout_q,   bout_d;
`ifdef CSEL_SUB_SIGNED_OVF_EN
  logic              ovf_q,    ovf_d;
`endif

  // -------------------------------------------------------------------------
  // Slice datapath
  // -------------------------------------------------------------------------
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] d0;
  logic [SLICE-1:0] d1;
  logic             bo0;
  logic             bo1;
  logic [SLICE-1:0] d_sel;
  logic             bo_sel;

  // Operand slice select, written as a compare-per-slice mux so the index
  // width never has to match the bit-offset arithmetic.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_s = a_q[i*SLICE +: SLICE];
        b_s = b_q[i*SLICE +: SLICE];
      end
    end
  end

  csel_sub_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_s (a_s),
    .b_s (b_s),
    .d0  (d0),
    .bo0 (bo0),
    .d1  (d1),
    .bo1 (bo1)
  );

  // Carry-select: the running borrow from the previous slice picks the
  // precomputed candidate.
  always_comb begin
    d_sel  = borrow_q ? d1  : d0;
    bo_sel = borrow_q ? bo1 : bo0;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef CSEL_SUB_SIGNED_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        // diff is left untouched here: it holds the last result until the
        // new operation overwrites it slice by slice.
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NUM_SLICES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            diff_d[i*SLICE +: SLICE] = d_sel;
          end
        end
        borrow_d = bo_sel;
        if (idx_q == LAST_IDX) begin
          bout_d  = bo_sel;
`ifdef CSEL_SUB_SIGNED_OVF_EN
          // The last slice holds the result MSB, so d_sel[SLICE-1] is the
          // final diff MSB.
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (d_sel[SLICE-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

`ifdef CSEL_SUB_SIGNED_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule

// File: tb/tb_csel_iter_subtractor.sv
// ---------------------------------------------------------------------------
// tb_csel_iter_subtractor
//
// Self-checking bench for csel_iter_subtractor at the default configuration
// (WIDTH=16, SLICE=4). Expected results come from an integer-arithmetic
// reference model pushed into exp_q at accept time and popped when the
// result is presented. Define CSEL_SUB_SIGNED_OVF_EN to also check ovf.
// ---------------------------------------------------------------------------
module tb_csel_iter_subtractor;

  localparam int W  = 16;
  localparam int NS = 4;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef CSEL_SUB_SIGNED_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  csel_iter_subtractor #(
    .WIDTH (W),
    .SLICE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef CSEL_SUB_SIGNED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_total = 0;
  int n_bad   = 0;

  // {ovf, bout, diff}
  logic [W+1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic bi);
    int           ua, ub, ud, sa, sb, sd;
    logic         o, bo;
    logic [W-1:0] dv;
    ua = int'(av);
    ub = int'(bv);
    ud = ua - ub - int'(bi);
    bo = (ud < 0);
    dv = W'(ud);
    sa = av[W-1] ? ua - (1 << W) : ua;
    sb = bv[W-1] ? ub - (1 << W) : ub;
    sd = sa - sb - int'(bi);
    o  = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return {o, bo, dv};
  endfunction

  // -------------------------------------------------------------------------
  // Driver
  // -------------------------------------------------------------------------
  // One full operation. hold = number of DONE cycles with out_ready low;
  // hold = 0 keeps out_ready high from accept onward (DONE lasts one cycle).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input int hold);
    int           cnt;
    logic [W+1:0] e;
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("in_ready_idle", in_ready, 1);
    a         = av;
    b         = bv;
    bin       = bi;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    exp_q.push_back(model(av, bv, bi));
    @(posedge clk);
    @(negedge clk);
    // Operand bus is garbage from here on; only the accept edge matters.
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    bin      = 1'($urandom_range(0, 1));
    if (hold == 0) out_ready = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("in_ready_busy", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, NS);
    e = exp_q.pop_front();
    check("diff", diff, e[W-1:0]);
    check("bout", bout, e[W]);
`ifdef CSEL_SUB_SIGNED_OVF_EN
    check("ovf", ovf, e[W+1]);
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, e[W-1:0]);
      check("hold_bout", bout, e[W]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_diff_kept", diff, e[W-1:0]);
  endtask

  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  logic [W-1:0] edge_vals[5];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
`ifdef CSEL_SUB_SIGNED_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(16'h1234, 16'h0234, 1'b0, 0);
    run_op(16'h0000, 16'h0001, 1'b0, 1);
    run_op(16'h0005, 16'h0005, 1'b1, 0);
    run_op(16'h0005, 16'h0005, 1'b0, 2);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    // Backpressure: three stalled DONE cycles with in_valid noise
    run_op(16'hABCD, 16'h1234, 1'b1, 3);
    // Signed overflow corners
    run_op(16'h8000, 16'h0001, 1'b0, 0);
    run_op(16'h0001, 16'h0002, 1'b0, 1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    run_op(16'h8000, 16'h0000, 1'b1, 0);

    // Reset in the middle of RUN (slice index 2)
    a        = 16'h1234;
    b        = 16'h0111;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_diff", diff, 0);
    check("midrun_rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'h00FF, 16'h000F, 1'b0, 1);

    // Randomized operations, biased towards boundary operands
    edge_vals[0] = 16'h0000;
    edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h8000;
    edge_vals[3] = 16'h7FFF;
    edge_vals[4] = 16'h0001;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
